gpu_line_drawer: RTL and testbench

GPU_LINE_DRAWER -- requirements
Module: gpu_line_drawer

---
 rtl/gpu_line_drawer.sv | 182 ++++++++++++++++++
 tb/tb_gpu_line_drawer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_line_drawer.sv
// Bresenham line rasteriser for the GPU controller.
// Latches a pair of endpoints when run_line_i rises, computes the step terms in a
// one-cycle setup state, then streams one pixel per accepted handshake until the
// far endpoint is written. finished_line_o stays high until the controller drops
// run_line_i. Dropping run_line_i early aborts the line without a finish pulse.
//
// Ports
//   clk, rst                  : rising-edge clock, synchronous active-high reset
//   x1_i/y1_i/x2_i/y2_i       : line endpoints, sampled only in idle
//   run_line_i                : held high for the whole command
//   r_i/g_i/b_i               : line colour, sampled in setup
//   finished_line_o           : line complete (done state)
//   pix_x_o/pix_y_o           : current pixel coordinate
//   pix_r_o/pix_g_o/pix_b_o   : pixel colour
//   pix_valid_o/pix_ready_i   : pixel write handshake
module gpu_line_drawer #(
  parameter int unsigned WIDTH_BITS   = 10,
  parameter int unsigned HEIGHT_BITS  = 9,
  parameter int unsigned CHANNEL_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic                    run_line_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  output logic                    finished_line_o,
  output logic [WIDTH_BITS-1:0]   pix_x_o,
  output logic [HEIGHT_BITS-1:0]  pix_y_o,
  output logic [CHANNEL_BITS-1:0] pix_r_o,
  output logic [CHANNEL_BITS-1:0] pix_g_o,
  output logic [CHANNEL_BITS-1:0] pix_b_o,
  output logic                    pix_valid_o,
  input  logic                    pix_ready_i
);

  localparam int unsigned MaxBits = (WIDTH_BITS > HEIGHT_BITS) ? WIDTH_BITS : HEIGHT_BITS;
  // Two extra bits: one for the sign, one so that 2*err cannot overflow.
  localparam int unsigned SBits = MaxBits + 2;

  localparam logic [WIDTH_BITS-1:0]  XOne = 1;
  localparam logic [HEIGHT_BITS-1:0] YOne = 1;

  typedef enum logic [1:0] {StIdle, StSetup, StDraw, StDone} state_e;

  state_e                   state_q, state_d;
  logic [WIDTH_BITS-1:0]    x1_q, x1_d, x2_q, x2_d, cur_x_q, cur_x_d;
  logic [HEIGHT_BITS-1:0]   y1_q, y1_d, y2_q, y2_d, cur_y_q, cur_y_d;
  logic                     sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [SBits-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic [CHANNEL_BITS-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;

  logic signed [SBits-1:0]  x1_s, x2_s, y1_s, y2_s, dx_abs, dy_neg, e2;

  assign x1_s   = $signed({{(SBits-WIDTH_BITS){1'b0}}, x1_q});
  assign x2_s   = $signed({{(SBits-WIDTH_BITS){1'b0}}, x2_q});
  assign y1_s   = $signed({{(SBits-HEIGHT_BITS){1'b0}}, y1_q});
  assign y2_s   = $signed({{(SBits-HEIGHT_BITS){1'b0}}, y2_q});
  assign dx_abs = (x2_s >= x1_s) ? (x2_s - x1_s) : (x1_s - x2_s);
  assign dy_neg = (y2_s >= y1_s) ? (y1_s - y2_s) : (y2_s - y1_s);
  assign e2     = err_q <<< 1;

  always_comb begin
    state_d  = state_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    x2_d     = x2_q;
    y2_d     = y2_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;

    unique case (state_q)
      StIdle: begin
        if (run_line_i) begin
          x1_d    = x1_i;
          y1_d    = y1_i;
          x2_d    = x2_i;
          y2_d    = y2_i;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (!run_line_i) begin
          state_d = StIdle;
        end else begin
          dx_d     = dx_abs;
          dy_d     = dy_neg;
          sx_neg_d = (x2_q < x1_q);
          sy_neg_d = (y2_q < y1_q);
          err_d    = dx_abs + dy_neg;
          cur_x_d  = x1_q;
          cur_y_d  = y1_q;
          // Controller colour is only valid from the second command cycle.
          r_d      = r_i;
          g_d      = g_i;
          b_d      = b_i;
          state_d  = StDraw;
        end
      end
      StDraw: begin
        if (!run_line_i) begin
          state_d = StIdle;
        end else if (pix_ready_i) begin
          if (cur_x_q == x2_q && cur_y_q == y2_q) begin
            state_d = StDone;
          end else begin
            // Both tests use the pre-step error term e2.
            if (e2 >= dy_q) begin
              err_d   = err_d + dy_q;
              cur_x_d = sx_neg_q ? (cur_x_q - XOne) : (cur_x_q + XOne);
            end
            if (e2 <= dx_q) begin
              err_d   = err_d + dx_q;
              cur_y_d = sy_neg_q ? (cur_y_q - YOne) : (cur_y_q + YOne);
            end
          end
        end
      end
      StDone: begin
        if (!run_line_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      x1_q     <= '0;
      y1_q     <= '0;
      x2_q     <= '0;
      y2_q     <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      x2_q     <= x2_d;
      y2_q     <= y2_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign pix_valid_o     = (state_q == StDraw);
  assign finished_line_o = (state_q == StDone);
  assign pix_x_o         = cur_x_q;
  assign pix_y_o         = cur_y_q;
  assign pix_r_o         = r_q;
  assign pix_g_o         = g_q;
  assign pix_b_o         = b_q;

endmodule

// File: tb/tb_gpu_line_drawer.sv
// Scoreboard bench for gpu_line_drawer: expected pixels are pushed when a command
// is issued and popped as the DUT hands pixels over.
module tb_gpu_line_drawer;

  localparam int WB = 10;
  localparam int HB = 9;
  localparam int CB = 8;

  typedef struct packed {
    logic [WB-1:0] x;
    logic [HB-1:0] y;
    logic [23:0]   c;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [WB-1:0] x1_i, x2_i;
  logic [HB-1:0] y1_i, y2_i;
  logic          run_line_i;
  logic [CB-1:0] r_i, g_i, b_i;
  logic          finished_line_o;
  logic [WB-1:0] pix_x_o;
  logic [HB-1:0] pix_y_o;
  logic [CB-1:0] pix_r_o, pix_g_o, pix_b_o;
  logic          pix_valid_o;
  logic          pix_ready_i;

  int   n_checks = 0;
  int   n_errors = 0;
  pix_t sb_q[$];

  always #5 clk = ~clk;

  gpu_line_drawer #(
    .WIDTH_BITS  (WB),
    .HEIGHT_BITS (HB),
    .CHANNEL_BITS(CB)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .x1_i           (x1_i),
    .y1_i           (y1_i),
    .x2_i           (x2_i),
    .y2_i           (y2_i),
    .run_line_i     (run_line_i),
    .r_i            (r_i),
    .g_i            (g_i),
    .b_i            (b_i),
    .finished_line_o(finished_line_o),
    .pix_x_o        (pix_x_o),
    .pix_y_o        (pix_y_o),
    .pix_r_o        (pix_r_o),
    .pix_g_o        (pix_g_o),
    .pix_b_o        (pix_b_o),
    .pix_valid_o    (pix_valid_o),
    .pix_ready_i    (pix_ready_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference rasteriser: pushes every pixel of the line onto the scoreboard.
  task automatic push_line(input int x1, input int y1, input int x2, input int y2,
                           input logic [23:0] col);
    int dx, dy, sx, sy, err, e2, x, y;
    pix_t p;
    dx  = iabs(x2 - x1);
    dy  = -iabs(y2 - y1);
    sx  = (x2 >= x1) ? 1 : -1;
    sy  = (y2 >= y1) ? 1 : -1;
    err = dx + dy;
    x   = x1;
    y   = y1;
    for (int guard = 0; guard < 4096; guard++) begin
      p.x = WB'(x);
      p.y = HB'(y);
      p.c = col;
      sb_q.push_back(p);
      if (x == x2 && y == y2) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // One command. stop_after >= 0 ends the line after that many accepts, either by
  // dropping run_line_i (abort) or by asserting rst with a pixel on offer.
  task automatic do_line(input int x1, input int y1, input int x2, input int y2,
                         input logic [23:0] col, input bit toggle,
                         input int stop_after, input bit stop_rst);
    int   acc, last_acc_k, exp_n;
    bit   done, stopped, prev_hold;
    pix_t p;
    logic [WB+HB-1:0] prev_xy;
    logic [23:0]      prev_c;
    exp_n = ((iabs(x2 - x1) > iabs(y2 - y1)) ? iabs(x2 - x1) : iabs(y2 - y1)) + 1;
    push_line(x1, y1, x2, y2, col);

    // Cycle C: command presented in idle, colour not yet valid.
    @(posedge clk); #1;
    rst         = 1'b0;
    run_line_i  = 1'b1;
    x1_i        = WB'(x1);
    y1_i        = HB'(y1);
    x2_i        = WB'(x2);
    y2_i        = HB'(y2);
    {r_i, g_i, b_i} = ~col;
    pix_ready_i = 1'b1;
    @(negedge clk);
    check("c0_valid", 32'(pix_valid_o), 32'd0);
    check("c0_finished", 32'(finished_line_o), 32'd0);

    // Cycle C+1: colour valid; endpoints scrambled to prove they are ignored.
    @(posedge clk); #1;
    {r_i, g_i, b_i} = col;
    x1_i = ~x1_i;
    y1_i = ~y1_i;
    x2_i = ~x2_i;
    y2_i = ~y2_i;
    @(negedge clk);
    check("c1_valid", 32'(pix_valid_o), 32'd0);

    acc        = 0;
    last_acc_k = 0;
    done       = 1'b0;
    stopped    = 1'b0;
    prev_hold  = 1'b0;
    prev_xy    = '0;
    prev_c     = '0;
    for (int k = 2; k < 3000 && !done && !stopped; k++) begin
      @(posedge clk); #1;
      if (stop_after >= 0 && acc == stop_after) begin
        if (stop_rst) begin
          rst         = 1'b1;
          pix_ready_i = 1'b1;
        end else begin
          run_line_i  = 1'b0;
          pix_ready_i = 1'b0;
        end
        stopped = 1'b1;
      end else begin
        pix_ready_i = toggle ? ((k % 2) == 0) : 1'b1;
      end
      @(negedge clk);
      if (k == 2) check("first_valid_latency", 32'(pix_valid_o), 32'd1);
      if (stopped) begin
        if (stop_rst) check("valid_at_rst", 32'(pix_valid_o), 32'd1);
      end else begin
        if (prev_hold && pix_valid_o) begin
          check("stable_xy", 32'({pix_x_o, pix_y_o}), 32'(prev_xy));
          check("stable_rgb", 32'({pix_r_o, pix_g_o, pix_b_o}), 32'(prev_c));
        end
        prev_hold = pix_valid_o && !pix_ready_i;
        prev_xy   = {pix_x_o, pix_y_o};
        prev_c    = {pix_r_o, pix_g_o, pix_b_o};
        if (pix_valid_o && pix_ready_i) begin
          if (sb_q.size() == 0) begin
            check("extra_pixel", 32'd1, 32'd0);
          end else begin
            p = sb_q.pop_front();
            check("pix_x", 32'(pix_x_o), 32'(p.x));
            check("pix_y", 32'(pix_y_o), 32'(p.y));
            check("pix_rgb", 32'({pix_r_o, pix_g_o, pix_b_o}), 32'(p.c));
          end
          acc++;
          last_acc_k = k;
        end
        if (finished_line_o) begin
          done = 1'b1;
          check("finish_latency", 32'(k), 32'(last_acc_k + 1));
          check("done_valid", 32'(pix_valid_o), 32'd0);
        end
      end
    end

    if (!done && !stopped) check("timeout", 32'd0, 32'd1);

    if (done) begin
      check("pix_count", 32'(acc), 32'(exp_n));
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      @(posedge clk); #1;
      run_line_i = 1'b0;
      @(negedge clk);
      check("done_held", 32'(finished_line_o), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_finished", 32'(finished_line_o), 32'd0);
      check("idle_valid", 32'(pix_valid_o), 32'd0);
    end

    if (stopped) begin
      @(posedge clk); #1;
      rst        = 1'b0;
      run_line_i = 1'b0;
      @(negedge clk);
      check("stop_valid", 32'(pix_valid_o), 32'd0);
      check("stop_finished", 32'(finished_line_o), 32'd0);
      if (stop_rst) begin
        check("rst_xy", 32'({pix_x_o, pix_y_o}), 32'd0);
        check("rst_rgb", 32'({pix_r_o, pix_g_o, pix_b_o}), 32'd0);
      end else begin
        check("abort_accepts", 32'(acc), 32'(stop_after));
      end
      @(posedge clk); #1;
      @(negedge clk);
      check("stop_no_finish", 32'(finished_line_o), 32'd0);
      sb_q.delete();
    end
  endtask

  int lines [14][4] = '{
    '{20, 20, 25, 22}, '{20, 20, 22, 26}, '{20, 20, 15, 23}, '{20, 20, 18, 27},
    '{20, 20, 14, 17}, '{20, 20, 17, 12}, '{20, 20, 27, 15}, '{20, 20, 21, 11},
    '{3, 3, 8, 8},     '{4, 9, 4, 2},     '{9, 0, 2, 0},     '{8, 8, 3, 13},
    '{0, 0, 1023, 511}, '{1023, 0, 0, 511}
  };

  initial begin
    rst         = 1'b1;
    run_line_i  = 1'b1;
    x1_i        = '0;
    y1_i        = '0;
    x2_i        = 10'd3;
    y2_i        = '0;
    {r_i, g_i, b_i} = 24'h5A5A5A;
    pix_ready_i = 1'b1;

    // Two reset cycles with a command already requested.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(pix_valid_o), 32'd0);
      check("rst_finished", 32'(finished_line_o), 32'd0);
      check("rst_pix", 32'({pix_x_o, pix_y_o}), 32'd0);
    end

    do_line(0, 0, 3, 0, 24'hA1B2C3, 1'b0, -1, 1'b0);
    do_line(2, 5, 2, 5, 24'h112233, 1'b0, -1, 1'b0);
    do_line(5, 4, 0, 1, 24'h445566, 1'b1, -1, 1'b0);
    do_line(0, 0, 9, 7, 24'h778899, 1'b0, 3, 1'b0);
    do_line(1, 1, 1, 3, 24'hAABBCC, 1'b0, -1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      do_line(lines[i][0], lines[i][1], lines[i][2], lines[i][3],
              24'(32'h10203 * (i + 1)), (i % 2) == 1, -1, 1'b0);
    end
    do_line(0, 0, 9, 9, 24'hDDEEFF, 1'b0, 2, 1'b1);
    do_line(3, 3, 0, 0, 24'h0F1E2D, 1'b1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
